// File: rtl/dac_spi_pkg.sv
// dac_spi_pkg: shared state encoding and default timing constants for the DAC SPI master
package dac_spi_pkg;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_SETUP    = 3'd1,
      ST_SHIFT    = 3'd2,
      ST_HOLD     = 3'd3,
      ST_DONE     = 3'd4,
      ST_WAIT_REL = 3'd5
   } state_t;

   localparam int DAC_WORD_W   = 24;
   localparam int DEF_CLK_DIV  = 4;
   localparam int DEF_CS_SETUP = 2;
   localparam int DEF_CS_HOLD  = 2;

endpackage

// File: rtl/spi_bit_tick.sv
// spi_bit_tick: SCLK half-period divider giving half_tick (rising sclk) and bit_end (end of bit) strobes
module spi_bit_tick
   import dac_spi_pkg::*;
#(
   parameter int P_CLK_DIV = DEF_CLK_DIV
)(
   input  logic clk,
   input  logic rst_n,
   input  logic en,
   output logic half_tick,
   output logic bit_end
);

   localparam int CW = $clog2(2 * P_CLK_DIV);

   logic [CW-1:0] cnt;

   assign half_tick = en && (cnt == CW'(P_CLK_DIV - 1));
   assign bit_end   = en && (cnt == CW'(2 * P_CLK_DIV - 1));

   // count clk cycles within one bit; held at zero outside SHIFT so every bit starts aligned
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n)
         cnt <= '0;
      else if (!en || bit_end)
         cnt <= '0;
      else
         cnt <= cnt + 1'b1;

endmodule

// File: rtl/dac_spi_master.sv
// dac_spi_master: serialises a DAC command word MSB first onto sclk/mosi with two chip selects; define DAC_SPI_READBACK_EN to add miso capture into rd_data
module dac_spi_master
   import dac_spi_pkg::*;
#(
   parameter int P_WIDTH    = DAC_WORD_W,
   parameter int P_CLK_DIV  = DEF_CLK_DIV,
   parameter int P_CS_SETUP = DEF_CS_SETUP,
   parameter int P_CS_HOLD  = DEF_CS_HOLD
)(
   input  logic               clk,
   input  logic               rst_n,
   input  logic               wr_req,
   input  logic               sel,
   input  logic [P_WIDTH-1:0] wr_data,
`ifdef DAC_SPI_READBACK_EN
   input  logic               miso,
   output logic [P_WIDTH-1:0] rd_data,
`endif
   output logic               ack,
   output logic               busy,
   output logic               sclk,
   output logic               mosi,
   output logic               cs0_n,
   output logic               cs1_n
);

   localparam int BW = (P_WIDTH > 1) ? $clog2(P_WIDTH) : 1;

   state_t             state;
   logic [P_WIDTH-2:0] sh;
   logic [BW-1:0]      bit_cnt;
   logic [15:0]        wait_cnt;
   logic               half_tick;
   logic               bit_end;

   spi_bit_tick #(.P_CLK_DIV(P_CLK_DIV)) u_tick (
      .clk       (clk),
      .rst_n     (rst_n),
      .en        (state == ST_SHIFT),
      .half_tick (half_tick),
      .bit_end   (bit_end)
   );

   // transfer sequencer; mosi holds the current bit, sh the bits still to send
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state    <= ST_IDLE;
         ack      <= 1'b0;
         busy     <= 1'b0;
         sclk     <= 1'b1;
         mosi     <= 1'b0;
         cs0_n    <= 1'b1;
         cs1_n    <= 1'b1;
         sh       <= '0;
         bit_cnt  <= '0;
         wait_cnt <= '0;
      end else begin
         ack <= 1'b0;
         case (state)
            ST_IDLE:
               if (wr_req) begin
                  sh       <= wr_data[P_WIDTH-2:0];
                  mosi     <= wr_data[P_WIDTH-1];
                  cs0_n    <= sel;
                  cs1_n    <= !sel;
                  busy     <= 1'b1;
                  wait_cnt <= '0;
                  state    <= ST_SETUP;
               end
            ST_SETUP:
               if (wait_cnt == 16'(P_CS_SETUP - 1)) begin
                  sclk    <= 1'b0;
                  bit_cnt <= '0;
                  state   <= ST_SHIFT;
               end else
                  wait_cnt <= wait_cnt + 1'b1;
            ST_SHIFT:
               if (half_tick)
                  sclk <= 1'b1;
               else if (bit_end) begin
                  if (bit_cnt == BW'(P_WIDTH - 1)) begin
                     wait_cnt <= '0;
                     state    <= ST_HOLD;
                  end else begin
                     sclk    <= 1'b0;
                     mosi    <= sh[P_WIDTH-2];
                     sh      <= sh << 1;
                     bit_cnt <= bit_cnt + 1'b1;
                  end
               end
            ST_HOLD:
               if (wait_cnt == 16'(P_CS_HOLD - 1)) begin
                  cs0_n <= 1'b1;
                  cs1_n <= 1'b1;
                  mosi  <= 1'b0;
                  state <= ST_DONE;
               end else
                  wait_cnt <= wait_cnt + 1'b1;
            ST_DONE: begin
               ack   <= 1'b1;
               busy  <= 1'b0;
               state <= ST_WAIT_REL;
            end
            ST_WAIT_REL:
               if (!wr_req)
                  state <= ST_IDLE;
            default:
               state <= ST_IDLE;
         endcase
      end

`ifdef DAC_SPI_READBACK_EN
   logic [P_WIDTH-1:0] cap;

   // capture miso on each sclk rising cycle and publish the word alongside ack
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         cap     <= '0;
         rd_data <= '0;
      end else if (half_tick)
         cap <= {cap[P_WIDTH-2:0], miso};
      else if (state == ST_DONE)
         rd_data <= cap;
`endif

endmodule
